// File: rtl/sd_image_loader.sv
// Multi-slot SD image loader: streams the selected image sector by sector through a
// 512-byte buffer onto the ioctl download bus, with auto-boot, reload and abort.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a pending slot or a reload request
// GO       | latch target, raise busy/download, clear error
// SETTLE   | settle down-counter, then issue one-hot sd_rd
// WAIT_SD  | sector read in flight, timeout down-counter running
// XFER     | paced ioctl writes out of the sector buffer
// DONE     | load finished, outputs already dropped
// ABORT    | load aborted (unmount/timeout), error set
module sd_image_loader #(
    parameter int          SLOTS      = 4,
    parameter int          ADDR_W     = 23,
    parameter int unsigned SETTLE     = 1508863,
    parameter int unsigned BYTE_GAP   = 31,
    parameter int unsigned SD_TIMEOUT = 24'hFFFFFF
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [SLOTS-1:0]           i_boot_mask,
    input  logic                       i_reload,
    input  logic [SLOTS-1:0]           i_img_mounted,
    input  logic [31:0]                i_img_size,
    output logic [31:0]                o_sd_lba,
    output logic [SLOTS-1:0]           o_sd_rd,
    input  logic                       i_sd_busy,
    input  logic                       i_sd_done,
    input  logic [8:0]                 i_sd_byte_index,
    input  logic [7:0]                 i_sd_rd_data,
    input  logic                       i_sd_rd_byte_strobe,
    output logic [SLOTS-1:0]           o_slot_present,
    output logic [$clog2(SLOTS)-1:0]   o_img_select,
    output logic [SLOTS-1:0]           o_load_sel,
    output logic                       o_loader_busy,
    output logic                       o_ioctl_download,
    output logic [ADDR_W-1:0]          o_ioctl_addr,
    output logic [7:0]                 o_ioctl_data,
    output logic                       o_ioctl_wr,
    input  logic                       i_ioctl_wait,
    output logic                       o_error
);
    localparam int SW = $clog2(SLOTS);
    localparam int SET_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam int TMO_W = (SD_TIMEOUT < 2) ? 1 : $clog2(SD_TIMEOUT + 1);
    // The reload of at least 1 gives the synchronous buffer read a cycle to follow cnt.
    localparam int unsigned GAP_RL = (BYTE_GAP > 1) ? BYTE_GAP - 1 : 1;
    localparam int GAP_W = (GAP_RL < 2) ? 1 : $clog2(GAP_RL + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_GO      = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_WAIT_SD = 3'd3;
    localparam logic [2:0] S_XFER    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_ABORT   = 3'd6;

    logic [2:0]        r_state;
    logic [SLOTS-1:0]  r_present;
    logic [SLOTS-1:0]  r_pending;
    logic [ADDR_W-1:0] r_last [SLOTS];
    logic [SW-1:0]     r_sel;
    logic              r_loaded;
    logic [SLOTS-1:0]  r_load_sel;
    logic              r_busy;
    logic              r_error;
    logic [31:0]       r_lba;
    logic [ADDR_W-1:0] r_addr;
    logic [SET_W-1:0]  r_settle;
    logic [TMO_W-1:0]  r_tmo;
    logic [GAP_W-1:0]  r_gap;
    logic [8:0]        r_cnt;
    logic [SLOTS-1:0]  r_sd_rd;
    logic              r_wr;
    logic [7:0]        r_data;
    logic [7:0]        r_buf [512];
    logic [7:0]        r_buf_q;

    logic [SW-1:0]     w_pick;
    logic              w_any_pending;
    logic              w_take;
    logic [SLOTS-1:0]  w_sel_oh;
    logic [32:0]       w_size_cl;
    logic [ADDR_W-1:0] w_last;
    logic              w_active;
    logic              w_unmount_active;
    logic              w_timeout;
    logic              w_abort;

    // Highest pending index wins.
    always_comb begin
        w_pick        = '0;
        w_any_pending = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (r_pending[i]) begin
                w_pick        = SW'(i);
                w_any_pending = 1'b1;
            end
        end
    end

    always_comb begin
        w_size_cl = {1'b0, i_img_size};
        if ({1'b0, i_img_size} > (33'd1 << ADDR_W))
            w_size_cl = 33'd1 << ADDR_W;
    end

    assign w_last           = ADDR_W'(w_size_cl - 33'd1);
    assign w_take           = (r_state == S_IDLE) && w_any_pending;
    assign w_sel_oh         = {{(SLOTS-1){1'b0}}, 1'b1} << r_sel;
    assign w_active         = (r_state == S_GO) || (r_state == S_SETTLE) ||
                              (r_state == S_WAIT_SD) || (r_state == S_XFER);
    assign w_unmount_active = i_img_mounted[r_sel] && (i_img_size == 32'd0);
    assign w_timeout        = (r_state == S_WAIT_SD) && (r_tmo == '0) && !i_sd_done;
    assign w_abort          = w_active && (w_unmount_active || w_timeout);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_present <= '0;
            r_pending <= '0;
            for (int i = 0; i < SLOTS; i++) r_last[i] <= '0;
        end else begin
            if (w_take) r_pending[w_pick] <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                if (i_img_mounted[i]) begin
                    if (i_img_size != 32'd0) begin
                        r_present[i] <= 1'b1;
                        r_last[i]    <= w_last;
                        if (i_boot_mask[i] && (i != 0)) r_pending[i] <= 1'b1;
                    end else begin
                        r_present[i] <= 1'b0;
                        r_pending[i] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_sd_rd_byte_strobe && i_sd_busy) r_buf[i_sd_byte_index] <= i_sd_rd_data;
        r_buf_q <= r_buf[r_cnt];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_sel      <= '0;
            r_loaded   <= 1'b0;
            r_load_sel <= '0;
            r_busy     <= 1'b0;
            r_error    <= 1'b0;
            r_lba      <= '0;
            r_addr     <= '0;
            r_settle   <= '0;
            r_tmo      <= '0;
            r_gap      <= '0;
            r_cnt      <= '0;
            r_sd_rd    <= '0;
            r_wr       <= 1'b0;
            r_data     <= '0;
        end else begin
            r_wr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_pending) begin
                        r_sel    <= w_pick;
                        r_loaded <= 1'b1;
                        r_state  <= S_GO;
                    end else if (i_reload && r_loaded && r_present[r_sel]) begin
                        r_state <= S_GO;
                    end
                end
                S_GO: begin
                    r_load_sel <= w_sel_oh;
                    r_busy     <= 1'b1;
                    r_error    <= 1'b0;
                    r_lba      <= '0;
                    r_addr     <= '0;
                    r_settle   <= SET_W'(SETTLE);
                    r_state    <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_settle != '0) begin
                        r_settle <= r_settle - 1'b1;
                    end else if (!i_ioctl_wait) begin
                        r_sd_rd <= w_sel_oh;
                        r_tmo   <= TMO_W'(SD_TIMEOUT - 1);
                        r_state <= S_WAIT_SD;
                    end
                end
                S_WAIT_SD: begin
                    if (i_sd_busy) r_sd_rd <= '0;
                    if (r_tmo != '0) r_tmo <= r_tmo - 1'b1;
                    if (i_sd_done) begin
                        r_sd_rd <= '0;
                        r_cnt   <= '0;
                        r_gap   <= GAP_W'(1);
                        r_state <= S_XFER;
                    end
                end
                S_XFER: begin
                    // Post-write bookkeeping happens in the cycle the strobe is visible.
                    if (r_wr) begin
                        if (r_addr == r_last[r_sel]) begin
                            r_load_sel <= '0;
                            r_busy     <= 1'b0;
                            r_addr     <= '0;
                            r_state    <= S_DONE;
                        end else if (r_cnt == 9'd511) begin
                            r_lba    <= r_lba + 32'd1;
                            r_addr   <= r_addr + 1'b1;
                            r_settle <= SET_W'(1);
                            r_state  <= S_SETTLE;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                            r_cnt  <= r_cnt + 9'd1;
                            r_gap  <= GAP_W'(GAP_RL);
                        end
                    end else if (r_gap != '0) begin
                        r_gap <= r_gap - 1'b1;
                    end else if (!i_ioctl_wait) begin
                        r_wr   <= 1'b1;
                        r_data <= r_buf_q;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_ABORT: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            if (w_abort) begin
                r_load_sel <= '0;
                r_busy     <= 1'b0;
                r_addr     <= '0;
                r_sd_rd    <= '0;
                r_wr       <= 1'b0;
                r_error    <= 1'b1;
                r_state    <= S_ABORT;
            end
        end
    end

    assign o_sd_lba         = r_lba;
    assign o_sd_rd          = r_sd_rd;
    assign o_slot_present   = r_present;
    assign o_img_select     = r_sel;
    assign o_load_sel       = r_load_sel;
    assign o_loader_busy    = r_busy;
    assign o_ioctl_download = r_busy;
    assign o_ioctl_addr     = r_addr;
    assign o_ioctl_data     = r_data;
    assign o_ioctl_wr       = r_wr;
    assign o_error          = r_error;
endmodule

// File: tb/tb_sd_image_loader.sv
// Scoreboard bench for sd_image_loader: expected writes/sector requests are queued at
// stimulus time and popped by independent monitor and SD-model processes.
module tb_sd_image_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [3:0]  boot_mask, img_mounted;
    logic        reload;
    logic [31:0] img_size;
    logic [31:0] sd_lba;
    logic [3:0]  sd_rd;
    logic        sd_busy, sd_done, strobe;
    logic [8:0]  byte_index;
    logic [7:0]  rd_data;
    logic [3:0]  slot_present, load_sel;
    logic [1:0]  img_select;
    logic        loader_busy, ioctl_download, ioctl_wr, ioctl_wait, error;
    logic [22:0] ioctl_addr;
    logic [7:0]  ioctl_data;

    logic [3:0]  t_mounted;
    logic [31:0] t_size;
    logic [31:0] t_sd_lba;
    logic [3:0]  t_sd_rd, t_present, t_load_sel;
    logic [1:0]  t_select;
    logic        t_busy, t_download, t_wr, t_error;
    logic [22:0] t_addr;
    logic [7:0]  t_data;

    sd_image_loader #(.SLOTS(4), .ADDR_W(23), .SETTLE(16), .BYTE_GAP(3)) u_dut (
        .i_clk(clk), .i_reset(reset), .i_boot_mask(boot_mask), .i_reload(reload),
        .i_img_mounted(img_mounted), .i_img_size(img_size),
        .o_sd_lba(sd_lba), .o_sd_rd(sd_rd), .i_sd_busy(sd_busy), .i_sd_done(sd_done),
        .i_sd_byte_index(byte_index), .i_sd_rd_data(rd_data), .i_sd_rd_byte_strobe(strobe),
        .o_slot_present(slot_present), .o_img_select(img_select), .o_load_sel(load_sel),
        .o_loader_busy(loader_busy), .o_ioctl_download(ioctl_download),
        .o_ioctl_addr(ioctl_addr), .o_ioctl_data(ioctl_data), .o_ioctl_wr(ioctl_wr),
        .i_ioctl_wait(ioctl_wait), .o_error(error));

    sd_image_loader #(.SLOTS(4), .ADDR_W(23), .SETTLE(16), .BYTE_GAP(3), .SD_TIMEOUT(64)) u_tmo (
        .i_clk(clk), .i_reset(reset), .i_boot_mask(4'b1110), .i_reload(1'b0),
        .i_img_mounted(t_mounted), .i_img_size(t_size),
        .o_sd_lba(t_sd_lba), .o_sd_rd(t_sd_rd), .i_sd_busy(1'b0), .i_sd_done(1'b0),
        .i_sd_byte_index(9'd0), .i_sd_rd_data(8'd0), .i_sd_rd_byte_strobe(1'b0),
        .o_slot_present(t_present), .o_img_select(t_select), .o_load_sel(t_load_sel),
        .o_loader_busy(t_busy), .o_ioctl_download(t_download),
        .o_ioctl_addr(t_addr), .o_ioctl_data(t_data), .o_ioctl_wr(t_wr),
        .i_ioctl_wait(1'b0), .o_error(t_error));

    typedef struct { logic [22:0] addr; logic [7:0] data; logic [3:0] sel; bit first; bit last; } wr_t;
    typedef struct { logic [3:0] oh; logic [31:0] lba; } sd_t;
    wr_t wr_q[$];
    sd_t sd_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_wr     = 0;
    int last_wr_cyc = 0;
    bit chk_dl   = 1'b0;
    bit hold     = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] sd_byte(input int slot, input int lba, input int idx);
        return 8'(slot * 37 + lba * 11 + idx * 3 + (idx >> 8));
    endfunction

    task automatic push_load(input int slot, input int size);
        wr_t w;
        sd_t s;
        for (int l = 0; l < (size + 511) / 512; l++) begin
            s.oh  = 4'(1 << slot);
            s.lba = 32'(l);
            sd_q.push_back(s);
        end
        for (int a = 0; a < size; a++) begin
            w.addr  = 23'(a);
            w.data  = sd_byte(slot, a / 512, a % 512);
            w.sel   = 4'(1 << slot);
            w.first = (a == 0);
            w.last  = (a == size - 1);
            wr_q.push_back(w);
        end
    endtask

    task automatic mount(input logic [3:0] mask, input int size);
        @(negedge clk);
        img_mounted = mask;
        img_size    = 32'(size);
        @(negedge clk);
        img_mounted = 4'b0;
        img_size    = 32'd0;
    endtask

    task automatic tmount(input logic [3:0] mask, input int size);
        @(negedge clk);
        t_mounted = mask;
        t_size    = 32'(size);
        @(negedge clk);
        t_mounted = 4'b0;
        t_size    = 32'd0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        repeat (3) @(negedge clk);
        while ((wr_q.size() != 0 || sd_q.size() != 0 || ioctl_download) && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check(name, (wr_q.size() == 0 && sd_q.size() == 0 && !ioctl_download), 1);
        wr_q.delete();
        sd_q.delete();
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_wr(input int n, input string name);
        int k = 0;
        int tgt;
        tgt = n_wr + n;
        while (n_wr < tgt && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check(name, (n_wr >= tgt), 1);
    endtask

    // Write monitor / scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (chk_dl) begin
            check("download_fall", ioctl_download, 0);
            chk_dl = 1'b0;
        end
        if (ioctl_wr) begin
            n_wr++;
            if (wr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_wr: got addr 0x%0h expected no write", ioctl_addr);
            end else begin
                e = wr_q.pop_front();
                check("wr_addr", ioctl_addr, e.addr);
                check("wr_data", ioctl_data, e.data);
                check("wr_sel", load_sel, e.sel);
                if (!e.first) check("wr_gap", ((cyc - last_wr_cyc) >= 4), 1);
                if (e.last) chk_dl = 1'b1;
            end
            check("no_wr_in_hold", hold, 0);
            last_wr_cyc = cyc;
        end
    end

    // SD controller model.
    always begin
        sd_t s;
        int  slot;
        int  lba;
        @(negedge clk);
        if (!reset && sd_rd != 4'b0 && !sd_busy) begin
            if (sd_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_sd_rd: got 0x%0h lba %0d expected none", sd_rd, sd_lba);
            end else begin
                s = sd_q.pop_front();
                check("sd_rd_oh", sd_rd, s.oh);
                check("sd_lba", sd_lba, s.lba);
            end
            slot = 0;
            for (int i = 0; i < 4; i++) if (sd_rd[i]) slot = i;
            lba = int'(sd_lba);
            sd_busy = 1'b1;
            for (int i = 0; i < 512; i++) begin
                @(negedge clk);
                strobe     = 1'b1;
                byte_index = 9'(i);
                rd_data    = sd_byte(slot, lba, i);
            end
            @(negedge clk);
            strobe  = 1'b0;
            sd_done = 1'b1;
            @(negedge clk);
            sd_done = 1'b0;
            sd_busy = 1'b0;
        end
    end

    initial begin
        int k;
        int c0;
        int c1;
        int base;
        reset = 1'b1;
        boot_mask = 4'b1110; img_mounted = 4'b0; img_size = 32'd0; reload = 1'b0;
        sd_busy = 1'b0; sd_done = 1'b0; strobe = 1'b0; byte_index = 9'd0; rd_data = 8'd0;
        ioctl_wait = 1'b0; t_mounted = 4'b0; t_size = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_download", ioctl_download, 0);
        check("rst_busy", loader_busy, 0);
        check("rst_load_sel", load_sel, 0);
        check("rst_sd_rd", sd_rd, 0);
        check("rst_present", slot_present, 0);
        check("rst_wr", ioctl_wr, 0);
        check("rst_addr", ioctl_addr, 0);
        check("rst_data", ioctl_data, 0);
        check("rst_lba", sd_lba, 0);
        check("rst_select", img_select, 0);
        check("rst_error", error, 0);
        check("rst_tmo_outs", ({t_sd_lba, t_sd_rd, t_present, t_select, t_load_sel, t_busy,
                                t_download, t_addr, t_data, t_wr, t_error} != 0), 0);
        reset = 1'b0;

        // SD timeout on the short-timeout instance.
        tmount(4'b0010, 100);
        k = 0;
        while (t_sd_rd == 4'b0 && k < 200) begin @(negedge clk); k++; end
        check("tmo_sd_rd", t_sd_rd, 4'b0010);
        c0 = cyc;
        k = 0;
        while (!t_error && k < 200) begin @(negedge clk); k++; end
        c1 = cyc;
        check("tmo_cycles", 32'(c1 - c0), 64);
        check("tmo_download", t_download, 0);
        check("tmo_load_sel", t_load_sel, 0);
        tmount(4'b0100, 10);
        k = 0;
        while (!t_download && k < 50) begin @(negedge clk); k++; end
        check("tmo_dl_rise", t_download, 1);
        check("tmo_err_clear", t_error, 0);

        // Two-sector image with a partial last sector.
        push_load(1, 1000);
        mount(4'b0010, 1000);
        wait_idle("load_1000");
        check("select_after_1000", img_select, 1);

        // Simultaneous mounts: highest slot first.
        push_load(3, 150);
        push_load(2, 150);
        mount(4'b1100, 150);
        wait_idle("load_3_then_2");
        check("select_after_pair", img_select, 2);

        // Manual reload of the last loaded slot.
        push_load(2, 150);
        @(negedge clk); reload = 1'b1;
        @(negedge clk); reload = 1'b0;
        wait_idle("reload_2");

        // Exactly one sector.
        push_load(1, 512);
        mount(4'b0010, 512);
        wait_idle("load_512");
        repeat (100) @(negedge clk);

        // Size-0 mount and slot 0 exclusion from auto-boot.
        mount(4'b0010, 0);
        repeat (2) @(negedge clk);
        check("present_after_unmount", slot_present, 4'b1100);
        boot_mask = 4'b1111;
        mount(4'b0001, 100);
        repeat (2) @(negedge clk);
        check("present_slot0", slot_present, 4'b1101);
        c0 = 0;
        repeat (50) begin @(negedge clk); if (ioctl_download || sd_rd != 0) c0 = 1; end
        check("no_load_slot0", c0, 0);

        // ioctl_wait hold mid-sector.
        push_load(3, 700);
        mount(4'b1000, 700);
        wait_wr(50, "reach_hold_point");
        ioctl_wait = 1'b1;
        @(negedge clk);
        hold = 1'b1;
        base = n_wr;
        repeat (99) @(negedge clk);
        check("hold_no_wr", 32'(n_wr - base), 0);
        hold = 1'b0;
        ioctl_wait = 1'b0;
        wait_idle("load_700_hold");

        // Unmount of the active slot mid-sector.
        push_load(2, 900);
        mount(4'b0100, 900);
        wait_wr(20, "reach_abort_point");
        @(negedge clk);
        img_mounted = 4'b0100;
        img_size    = 32'd0;
        @(negedge clk);
        img_mounted = 4'b0;
        wr_q.delete();
        sd_q.delete();
        check("abort_error", error, 1);
        check("abort_download", ioctl_download, 0);
        check("abort_load_sel", load_sel, 0);
        check("abort_present", slot_present, 4'b1001);
        repeat (50) @(negedge clk);

        // Next load clears the sticky error.
        push_load(1, 50);
        mount(4'b0010, 50);
        k = 0;
        while (!ioctl_download && k < 50) begin @(negedge clk); k++; end
        check("err_clear_dl", ioctl_download, 1);
        check("err_clear", error, 0);
        wait_idle("load_50");

        // Async reset mid-load.
        push_load(3, 300);
        mount(4'b1000, 300);
        wait_wr(10, "reach_reset_point");
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_wr", ioctl_wr, 0);
        check("arst_download", ioctl_download, 0);
        check("arst_busy", loader_busy, 0);
        check("arst_load_sel", load_sel, 0);
        check("arst_sd_rd", sd_rd, 0);
        check("arst_addr", ioctl_addr, 0);
        check("arst_present", slot_present, 0);
        check("arst_lba", sd_lba, 0);
        wr_q.delete();
        sd_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (60) @(negedge clk);
        check("post_rst_download", ioctl_download, 0);
        check("post_rst_present", slot_present, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sd_image_loader.md
# sd_image_loader

Parametrised multi-slot SD-card image loader: watches N mounted image slots, streams the selected image sector by sector from the SD controller through an internal 512-byte buffer, and emits it on the ioctl download bus to the core (CRT/PRG/ROM loaders). Successor to the fixed 4-slot loader, adding:
- parametrised slot count and widths;
- exact byte-count termination with partial final sector;
- per-slot auto-boot mask and manual reload;
- SD timeout / unmount abort with a sticky error flag.

## Interface
Parameters:
- SLOTS, 4: number of image slots (2..8); slot 0 is never auto-loaded (drive image).
- ADDR_W, 23: ioctl address width; image sizes above 2^ADDR_W are clamped to 2^ADDR_W.
- SETTLE, 1508863: cycles waited after GO before the first sector request.
- BYTE_GAP, 31: idle cycles enforced between consecutive ioctl_wr pulses.
- SD_TIMEOUT, 24'hFFFFFF: cycles allowed from sd_rd assertion to sd_done.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- boot_mask  in  SLOTS  slot i loads automatically on mount when bit i is set.
- reload  in  1  one-cycle pulse; reloads the last loaded slot if it is still present.
- img_mounted  in  SLOTS  one-cycle mount strobe per slot.
- img_size  in  32  image byte size, valid with img_mounted.
- sd_lba  out  32  sector address.
- sd_rd  out  SLOTS  one-hot read request.
- sd_busy, sd_done  in  1  SD controller accepted / finished.
- sd_byte_index  in  9  byte position within sector.
- sd_rd_data  in  8  byte from SD.
- sd_rd_byte_strobe  in  1  byte valid.
- slot_present  out  SLOTS  slot has a nonzero image.
- img_select  out  $clog2(SLOTS)  slot being or last loaded.
- load_sel  out  SLOTS  one-hot target select, high for the whole load.
- loader_busy, ioctl_download  out  1  load in progress.
- ioctl_addr  out  ADDR_W; ioctl_data  out  8; ioctl_wr  out  1; ioctl_wait  in  1.
- error  out  1  sticky; cleared at the start of the next load.

## Operation
- Mount strobe i:
  - size != 0: present[i]=1, size latched. If boot_mask[i] and i != 0, pending[i]=1.
  - size == 0: present and pending for slot i cleared.
- States:
  - IDLE: when any pending bit is set, select the highest pending index; clear its pending bit; go to GO. reload with the last slot present goes to GO for that slot.
  - GO: set load_sel, loader_busy and ioctl_download; clear error; sd_lba=0, addr=0, settle counter=SETTLE. Go to SETTLE.
  - SETTLE: count down. At 0 with ioctl_wait low, assert sd_rd = one-hot(slot) and go to WAIT_SD.
  - WAIT_SD: sd_rd is dropped on the first cycle sd_busy is high. sd_done goes to XFER with cnt=0.
  - XFER: a byte is written when the gap counter has expired and ioctl_wait is low. After a write:
    - addr == size-1: go to DONE;
    - cnt == 511: sd_lba+1, go to SETTLE with counter=1;
    - otherwise stay in XFER.
  - DONE: drop load_sel, loader_busy and ioctl_download; ioctl_addr=0. Return to IDLE.
  - ABORT: same as DONE, and error=1.
- Buffer write port: written on sd_rd_byte_strobe && sd_busy at sd_byte_index. Read port: synchronous, addressed by cnt.
- Abort conditions, checked every cycle except IDLE:
  - unmount (size 0) of the active slot;
  - SD_TIMEOUT expiry in WAIT_SD.
- Mounts of other slots during a load only set pending; they are serviced after DONE.

## Timing
- Reset values: all outputs 0, state IDLE, present/pending cleared.
- ioctl_wr is a one-cycle pulse. ioctl_addr and ioctl_data are valid in the same cycle, because the buffer read is issued one cycle before.
- Consecutive ioctl_wr pulses are at least BYTE_GAP+1 cycles apart. ioctl_wait high stalls indefinitely with no data loss.
- Exactly size bytes are written, at addresses 0..size-1. A partial final sector writes only size mod 512 bytes.
- ioctl_download rises 1 cycle after leaving IDLE and falls 1 cycle after the last ioctl_wr.
- Async reset mid-load: everything returns to IDLE immediately with no further ioctl_wr; pending and present are cleared.
- reload while busy is ignored.

## Test plan
- SLOTS=4, SETTLE=16, BYTE_GAP=3; mount slot 1 with size 1000 and boot_mask=4'b1110 -> two sd_rd pulses (lba 0, 1); 1000 ioctl_wr at addresses 0..999; data equals model; ioctl_download falls 1 cycle after the last write.
- Mount slots 2 and 3 in the same cycle -> slot 3 loads first, then slot 2; load_sel=4'b1000 then 4'b0100.
- Size 512 -> exactly 512 writes, one sector, no second sd_rd. Size 0 mount -> slot_present bit stays 0, no load.
- ioctl_wait held high for 100 cycles mid-sector -> no ioctl_wr during the hold; resumes at the next address; writes never closer than 4 cycles apart.
- sd_done withheld with SD_TIMEOUT=64 -> error=1 at cycle 64; ioctl_download=0; next load clears error.
- Unmount the active slot mid-sector -> ABORT, error=1. Async reset mid-load -> all outputs 0 within the reset cycle.
